// File: rtl/execution_sequencer.sv
// execution_sequencer
// -------------------
// Sequences the single-cycle processor datapath. Each executed instruction
// produces exactly one commit strobe (exec_enable). That strobe gates PC
// update and register, memory and output writes. Supports free-run and
// single-step modes. IN instructions stall until the operator confirms the
// switch value. HALT parks the core until reset. Clocked from the divided
// system clock.
//
// Optional build macro: EXECUTION_SEQUENCER_BREAKPOINT_EN
//   When defined, adds a PC breakpoint. While the breakpoint matches, free run
//   drops to single-step behaviour, and break_hit reports the stop.
//
// Ports:
//   clock          in   divided system clock, rising edge
//   reset          in   asynchronous, active-low
//   run_mode       in   1 = free run, 0 = single-step
//   step_button    in   raw step button level (asynchronous)
//   input_confirm  in   raw confirm button level (asynchronous)
//   halt_decoded   in   current instruction is HALT
//   input_request  in   current instruction is IN
//   exec_enable    out  commit strobe for the current instruction
//   input_ready    out  one-cycle pulse: latch the switch value now
//   halted         out  registered, 1 while parked in HALT
//   state          out  FSM state (debug): 00 START, 01 RUN, 10 WAIT_INPUT, 11 HALT
//   retired_count  out  count of committed instructions (wraps)
//   pc, breakpoint_pc, breakpoint_valid, break_hit  (breakpoint build only)
//
// Commit protocol: exec_enable is a single-cycle strobe. The datapath samples
// it at the next rising edge and updates state only then. There is no
// back-pressure, and the strobe is never held for more than one instruction
// without a new go condition.

module execution_sequencer #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run_mode,
    input  logic                   step_button,
    input  logic                   input_confirm,
    input  logic                   halt_decoded,
    input  logic                   input_request,
    output logic                   exec_enable,
    output logic                   input_ready,
    output logic                   halted,
    output logic [1:0]             state,
`ifdef EXECUTION_SEQUENCER_BREAKPOINT_EN
    input  logic [31:0]            pc,
    input  logic [31:0]            breakpoint_pc,
    input  logic                   breakpoint_valid,
    output logic                   break_hit,
`endif
    output logic [COUNT_WIDTH-1:0] retired_count
);

    typedef enum logic [1:0] {
        START      = 2'b00,
        RUN        = 2'b01,
        WAIT_INPUT = 2'b10,
        HALT       = 2'b11
    } seq_state_t;

    seq_state_t state_q;
    seq_state_t state_d;

    // Two-flop synchronisers plus a history flop per button
    logic step_s1;
    logic step_s2;
    logic step_prev;
    logic confirm_s1;
    logic confirm_s2;
    logic confirm_prev;

    logic step_edge;
    logic confirm_edge;
    logic free_run;
    logic go;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_s1      <= 1'b0;
            step_s2      <= 1'b0;
            step_prev    <= 1'b0;
            confirm_s1   <= 1'b0;
            confirm_s2   <= 1'b0;
            confirm_prev <= 1'b0;
        end else begin
            step_s1      <= step_button;
            step_s2      <= step_s1;
            step_prev    <= step_s2;
            confirm_s1   <= input_confirm;
            confirm_s2   <= confirm_s1;
            confirm_prev <= confirm_s2;
        end
    end

    // Rising-edge detect. A held button yields one pulse, and an edge is only
    // consumed in the state that cares about it, so edges are never queued.
    assign step_edge    = step_s2 & ~step_prev;
    assign confirm_edge = confirm_s2 & ~confirm_prev;

`ifdef EXECUTION_SEQUENCER_BREAKPOINT_EN
    logic bp_match;

    // A breakpoint only matters while free running. On a match, the core
    // behaves as in step mode until a step edge commits the instruction.
    assign bp_match = (state_q == RUN) & run_mode & breakpoint_valid &
                      (pc == breakpoint_pc);
    assign free_run = run_mode & ~bp_match;

    // The hit flag clears on the committing step edge or on entry to HALT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            break_hit <= 1'b0;
        end else begin
            break_hit <= bp_match & ~step_edge & ~halt_decoded;
        end
    end
`else
    assign free_run = run_mode;
`endif

    assign go = free_run | step_edge;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exec_enable = 1'b0;
        input_ready = 1'b0;
        case (state_q)
            // Spend one cycle here so the first fetch sees a settled PC
            START: begin
                state_d = RUN;
            end
            RUN: begin
                // HALT wins over IN (illegal combination) and needs no go
                if (halt_decoded) begin
                    state_d = HALT;
                end else if (input_request && go) begin
                    state_d = WAIT_INPUT;
                end else if (go) begin
                    exec_enable = 1'b1;
                end
            end
            WAIT_INPUT: begin
                // step_edge is deliberately ignored here
                if (confirm_edge) begin
                    exec_enable = 1'b1;
                    input_ready = 1'b1;
                    state_d     = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted <= 1'b0;
        end else begin
            halted <= (state_d == HALT);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count <= '0;
        end else if (exec_enable) begin
            retired_count <= retired_count + COUNT_WIDTH'(1);
        end
    end

    assign state = state_q;

endmodule
